// File: rtl/parity_frame_ctrl_pkg.sv
// Shared definitions for the parity-checked frame controller.
// Holds the FSM state encoding and the error counter width.
package parity_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    RECV    = 2'd0,
    CHECK   = 2'd1,
    DELIVER = 2'd2,
    RETRY   = 2'd3
  } state_t;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/parity_frame_ctrl_parity_chk.sv
// Combinational odd-parity check for one received byte.
// A byte is good when the XOR of all its bits is 1.
module parity_chk #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  good
);

  assign good = ^data;

endmodule

// File: rtl/parity_frame_ctrl.sv
// Collects fixed-length frames of odd-parity bytes, delivers clean frames downstream,
// and requests retransmission (or drops the frame) when any byte fails parity.
module parity_frame_ctrl
  import parity_frame_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 4,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_byte,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_byte,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  retry_req,
  output logic                  frame_drop,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam int IDX_W   = $clog2(FRAME_LEN);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(FRAME_LEN - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  state_t                 state, state_next;
  logic [IDX_W-1:0]       wr_idx, rd_idx;
  logic [RETRY_W-1:0]     retry_cnt;
  logic                   frame_err;
  logic [DATA_WIDTH-1:0]  frame_buf [FRAME_LEN];
  logic                   byte_good, accept, deliver_hs;
  logic                   retry_next, drop_next;

  parity_chk #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data (in_byte),
    .good (byte_good)
  );

  assign in_ready   = (state == RECV);
  assign accept     = in_valid & in_ready;
  assign out_valid  = (state == DELIVER);
  assign out_last   = out_valid && (rd_idx == LAST_IDX);
  assign out_byte   = out_valid ? frame_buf[rd_idx] : '0;
  assign deliver_hs = out_valid & out_ready;

  always_comb begin
    state_next = state;
    retry_next = 1'b0;
    drop_next  = 1'b0;
    case (state)
      RECV:    if (accept && wr_idx == LAST_IDX) state_next = CHECK;
      CHECK: begin
        if (!frame_err) begin
          state_next = DELIVER;
        end else if (retry_cnt < RETRY_LIMIT) begin
          state_next = RETRY;
          retry_next = 1'b1;
        end else begin
          state_next = RECV;
          drop_next  = 1'b1;
        end
      end
      DELIVER: if (deliver_hs && out_last) state_next = RECV;
      RETRY:   state_next = RECV;
      default: state_next = RECV;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= RECV;
      wr_idx     <= '0;
      rd_idx     <= '0;
      retry_cnt  <= '0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
      retry_req  <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      state      <= state_next;
      retry_req  <= retry_next;
      frame_drop <= drop_next;

      if (state == CHECK)  wr_idx <= '0;
      else if (accept)     wr_idx <= wr_idx + IDX_W'(1);

      if (state == CHECK)                frame_err <= 1'b0;
      else if (accept && !byte_good)     frame_err <= 1'b1;

      if (state == CHECK) begin
        if (frame_err && retry_cnt < RETRY_LIMIT) retry_cnt <= retry_cnt + RETRY_W'(1);
        else                                      retry_cnt <= '0;
      end

      if (deliver_hs) rd_idx <= out_last ? '0 : rd_idx + IDX_W'(1);

      if (accept && !byte_good && err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

  // Buffer holds data only; contents are left alone on reset since indices restart at 0.
  for (genvar gi = 0; gi < FRAME_LEN; gi++) begin : g_buf
    always_ff @(posedge clk) begin
      if (accept && wr_idx == IDX_W'(gi)) frame_buf[gi] <= in_byte;
    end
  end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed bench for parity_frame_ctrl (FRAME_LEN=4, MAX_RETRY=2).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_parity_frame_ctrl;

  logic       clk = 1'b0;
  logic       arst;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_last;
  logic       out_ready;
  logic       retry_req;
  logic       frame_drop;
  logic [7:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  parity_frame_ctrl #(.DATA_WIDTH(8), .FRAME_LEN(4), .MAX_RETRY(2)) dut (
    .clk        (clk),
    .arst       (arst),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_byte   (out_byte),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .retry_req  (retry_req),
    .frame_drop (frame_drop),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame bytes are packed first-byte-in-MSBs: 32'h010780FE sends 01,07,80,FE.
  task automatic send_frame(input logic [31:0] frm);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("in_ready_recv", in_ready, 1);
      in_valid = 1'b1;
      in_byte  = frm[31-8*i -: 8];
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_check", in_ready, 0);
    chk("out_valid_check", out_valid, 0);
    $display("frame %h sent", frm);
  endtask

  task automatic expect_deliver(input logic [31:0] frm, input int stall_idx, input int stall_n);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == stall_idx) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_byte   = 8'h03;
        for (int k = 0; k < stall_n; k++) begin
          chk("stall_out_valid", out_valid, 1);
          chk("stall_out_byte", out_byte, frm[31-8*i -: 8]);
          chk("stall_in_ready", in_ready, 0);
          @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      chk("out_valid", out_valid, 1);
      chk("out_byte", out_byte, frm[31-8*i -: 8]);
      chk("out_last", out_last, (i == 3) ? 1 : 0);
      chk("in_ready_deliver", in_ready, 0);
      chk("retry_req_deliver", retry_req, 0);
    end
    @(negedge clk);
    chk("out_valid_done", out_valid, 0);
    chk("in_ready_done", in_ready, 1);
    $display("frame %h delivered", frm);
  endtask

  task automatic expect_retry();
    @(negedge clk);
    chk("retry_req_pulse", retry_req, 1);
    chk("out_valid_retry", out_valid, 0);
    chk("frame_drop_retry", frame_drop, 0);
    @(negedge clk);
    chk("retry_req_end", retry_req, 0);
    chk("in_ready_after_retry", in_ready, 1);
    $display("retry requested");
  endtask

  task automatic expect_drop();
    @(negedge clk);
    chk("frame_drop_pulse", frame_drop, 1);
    chk("retry_req_drop", retry_req, 0);
    chk("in_ready_drop", in_ready, 1);
    chk("out_valid_drop", out_valid, 0);
    @(negedge clk);
    chk("frame_drop_end", frame_drop, 0);
    $display("frame dropped");
  endtask

  initial begin
    arst      = 1'b1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_retry_req", retry_req, 0);
    chk("rst_frame_drop", frame_drop, 0);

    // Good frame: all bytes have odd weight.
    send_frame(32'h010780FE);
    expect_deliver(32'h010780FE, -1, 0);
    chk("good_err_cnt", err_cnt, 0);

    // Single retry: 0x03 has even weight, then a clean resend.
    send_frame(32'h010380FE);
    expect_retry();
    chk("retry_err_cnt", err_cnt, 1);
    send_frame(32'h0B1070F7);
    expect_deliver(32'h0B1070F7, -1, 0);

    // Drop: retry_cnt must have restarted at 0, so two retries precede the drop.
    send_frame(32'h03010101);
    expect_retry();
    send_frame(32'h01030101);
    expect_retry();
    send_frame(32'h01010103);
    expect_drop();
    chk("drop_err_cnt", err_cnt, 4);

    // Backpressure on byte index 2; bad bytes offered meanwhile must be ignored.
    send_frame(32'h010780FE);
    expect_deliver(32'h010780FE, 2, 5);
    chk("bp_err_cnt", err_cnt, 4);

    // Reset after two bytes delivered.
    send_frame(32'h010780FE);
    @(negedge clk);
    chk("pre_rst_byte0", out_byte, 8'h01);
    @(negedge clk);
    chk("pre_rst_byte1", out_byte, 8'h07);
    @(negedge clk);
    arst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_byte", out_byte, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    send_frame(32'h0B1070F7);
    expect_deliver(32'h0B1070F7, -1, 0);

    // Saturation: >300 bad bytes accepted over 500 cycles of continuous offer.
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      chk("sat_out_valid", out_valid, 0);
      in_valid = 1'b1;
      in_byte  = 8'h03;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("sat_err_cnt", err_cnt, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
